// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the two-port shifter arbiter.
package shift_arbiter_pkg;
    localparam int NPORT   = 2;
    localparam int WORD_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT2 = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic               lshift;
        logic               logical;
        logic               rot;
        logic [SHAMT_W-1:0] shamt;
        logic [WORD_W-1:0]  din;
    } req_t;
endpackage

// File: rtl/shift_arbiter_bshift.sv
// Combinational barrel shifter: left, logical right or arithmetic right.
module shift_arbiter_bshift
    import shift_arbiter_pkg::*;
(
    input  logic [WORD_W-1:0]  din,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               lshift,
    input  logic               logical,
    output logic [WORD_W-1:0]  dout
);
    always_comb begin
        if (lshift)
            dout = din << shamt;
        else if (logical)
            dout = din >> shamt;
        else
            dout = WORD_W'($signed(din) >>> shamt);
    end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters,
// with a two-pass rotate and a registered, held result.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int RR_INIT = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NPORT-1:0]           req_valid,
    output logic [NPORT-1:0]           req_ready,
    input  logic [NPORT-1:0]           req_lshift,
    input  logic [NPORT-1:0]           req_logical,
    input  logic [NPORT-1:0]           req_rot,
    input  logic [NPORT*SHAMT_W-1:0]   req_shift,
    input  logic [NPORT*WORD_W-1:0]    req_in,
    output logic [NPORT-1:0]           rsp_valid,
    input  logic [NPORT-1:0]           rsp_ready,
    output logic [WORD_W-1:0]          rsp_data,
    output logic                       busy
);
    state_t              state;
    logic                owner;
    logic                rr_last;
    logic [WORD_W-1:0]   rot_part;
    logic [WORD_W-1:0]   rot_in;
    logic [SHAMT_W-1:0]  rot_n;
    logic                rot_dir;

    req_t [NPORT-1:0]    req;
    req_t                sel;
    logic                g;
    logic                accept;
    logic                gnt;
    logic                rot_start;

    logic [WORD_W-1:0]   sh_din;
    logic [SHAMT_W-1:0]  sh_amt;
    logic                sh_left;
    logic                sh_log;
    logic [WORD_W-1:0]   sh_out;

    for (genvar i = 0; i < NPORT; i++) begin : g_req
        assign req[i] = {req_lshift[i], req_logical[i], req_rot[i],
                         req_shift[SHAMT_W*i +: SHAMT_W],
                         req_in[WORD_W*i +: WORD_W]};
        assign req_ready[i] = gnt & (g == 1'(i));
        assign rsp_valid[i] = (state == HOLD) & (owner == 1'(i));
    end

    // Under contention the port that did not win last time goes next.
    always_comb begin
        accept = (state == IDLE) | ((state == HOLD) & rsp_ready[owner]);
        case (req_valid)
            2'b01:   g = 1'b0;
            2'b10:   g = 1'b1;
            default: g = ~rr_last;
        endcase
        gnt       = accept & (|req_valid) & reset;
        sel       = req[g];
        rot_start = sel.rot & (|sel.shamt);
    end

    // Second rotate pass shifts the other way by 32-n and ORs with pass A.
    always_comb begin
        if (state == ROT2) begin
            sh_din  = rot_in;
            sh_amt  = ~rot_n + 5'd1;
            sh_left = ~rot_dir;
            sh_log  = 1'b1;
        end else begin
            sh_din  = sel.din;
            sh_amt  = sel.shamt;
            sh_left = sel.lshift;
            sh_log  = sel.logical | sel.rot;
        end
    end

    shift_arbiter_bshift u_bshift (
        .din     (sh_din),
        .shamt   (sh_amt),
        .lshift  (sh_left),
        .logical (sh_log),
        .dout    (sh_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr_last  <= 1'(RR_INIT);
            rot_part <= '0;
            rot_in   <= '0;
            rot_n    <= '0;
            rot_dir  <= 1'b0;
            rsp_data <= '0;
        end else if (state == ROT2) begin
            rsp_data <= rot_part | sh_out;
            state    <= HOLD;
        end else if (gnt) begin
            rr_last <= g;
            owner   <= g;
            if (rot_start) begin
                rot_part <= sh_out;
                rot_in   <= sel.din;
                rot_n    <= sel.shamt;
                rot_dir  <= sel.lshift;
                state    <= ROT2;
            end else begin
                rsp_data <= sh_out;
                state    <= HOLD;
            end
        end else if (accept && state == HOLD) begin
            state <= IDLE;
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized checks of shift_arbiter against a behavioural model.
module tb_shift_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = '0, req_ready, req_lshift = '0, req_logical = '0, req_rot = '0;
    logic [9:0]  req_shift = '0;
    logic [63:0] req_in = '0;
    logic [1:0]  rsp_valid, rsp_ready = '0;
    logic [31:0] rsp_data;
    logic        busy;

    int   tests = 0;
    int   errors = 0;
    logic exp_last;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    always #5 clock = ~clock;

    shift_arbiter #(.RR_INIT(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_lshift(req_lshift), .req_logical(req_logical), .req_rot(req_rot),
        .req_shift(req_shift), .req_in(req_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    function automatic logic [31:0] model(logic [31:0] d, int n, logic l, logic lg, logic r);
        if (r) begin
            if (n == 0) return d;
            return l ? ((d << n) | (d >> (32 - n))) : ((d >> n) | (d << (32 - n)));
        end
        if (l)  return d << n;
        if (lg) return d >> n;
        return 32'($signed(d) >>> n);
    endfunction

    task automatic set_req(int p, logic v, logic l, logic lg, logic r, logic [4:0] n, logic [31:0] d);
        req_valid[p]       = v;
        req_lshift[p]      = l;
        req_logical[p]     = lg;
        req_rot[p]         = r;
        req_shift[5*p +: 5] = n;
        req_in[32*p +: 32]  = d;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        #3;
        tests++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        tests++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
        tests++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        req_valid = 2'b00;
        tick();
        reset = 1'b1;
        exp_last = 1'b1;
        tick();
    endtask

    task automatic test_asr();
        rsp_ready = 2'b00;
        set_req(0, 1, 0, 0, 0, 4, 32'h8000_0000);
        #1;
        tests++; if (req_ready !== 2'b01) begin errors++; $display("FAIL asr_ready got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        tests++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL asr_valid got %b exp 01", rsp_valid); end
        tests++; if (rsp_data !== 32'hF800_0000) begin errors++; $display("FAIL asr_data got %h exp f8000000", rsp_data); end
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL asr_busy got %b exp 1", busy); end
        rsp_ready = 2'b01;
        tick();
        tests++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL asr_release got busy=%b valid=%b exp 0/00", busy, rsp_valid); end
        exp_last = 1'b0;
    endtask

    task automatic test_rot_left();
        rsp_ready = 2'b00;
        set_req(1, 1, 1, 0, 1, 1, 32'h8000_0001);
        #1;
        tests++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rotl_ready got %b exp 10", req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        tests++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin errors++; $display("FAIL rotl_pass2 got busy=%b valid=%b exp 1/00", busy, rsp_valid); end
        tests++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rotl_no_accept got %b exp 00", req_ready); end
        tick();
        tests++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rotl_valid got %b exp 10", rsp_valid); end
        tests++; if (rsp_data !== 32'h0000_0003) begin errors++; $display("FAIL rotl_data got %h exp 00000003", rsp_data); end
        rsp_ready = 2'b10;
        tick();
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rotl_release got %b exp 0", busy); end
        exp_last = 1'b1;
    endtask

    task automatic test_rot_right_zero();
        rsp_ready = 2'b00;
        set_req(0, 1, 0, 0, 1, 4, 32'h0000_0001);
        tick();
        req_valid = 2'b00;
        tests++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rotr_early got %b exp 00", rsp_valid); end
        tick();
        tests++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h1000_0000) begin errors++; $display("FAIL rotr_result got %b/%h exp 01/10000000", rsp_valid, rsp_data); end
        rsp_ready = 2'b01;
        set_req(0, 1, 0, 1, 1, 0, 32'h1234_5678);
        #1;
        tests++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rot0_ready got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tests++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL rot0_result got %b/%h exp 01/12345678", rsp_valid, rsp_data); end
        rsp_ready = 2'b01;
        tick();
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rot0_release got %b exp 0", busy); end
        exp_last = 1'b0;
    endtask

    task automatic test_contention();
        logic g;
        logic [31:0] want;
        rsp_ready = 2'b11;
        set_req(0, 1, 0, 1, 0, 1, 32'h0000_0100);
        set_req(1, 1, 1, 0, 0, 2, 32'h0000_0003);
        for (int k = 0; k < 6; k++) begin
            g = ~exp_last;
            #1;
            tests++; if (req_ready !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_grant%0d got %b exp port %0d", k, req_ready, g); end
            tick();
            want = g ? 32'h0000_000C : 32'h0000_0080;
            tests++; if (rsp_valid !== (g ? 2'b10 : 2'b01) || rsp_data !== want) begin errors++; $display("FAIL contention_rsp%0d got %b/%h exp port %0d/%h", k, rsp_valid, rsp_data, g, want); end
            exp_last = g;
        end
        req_valid = 2'b00;
        tick();
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL contention_drain got %b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 2'b00;
        set_req(0, 1, 1, 0, 0, 31, 32'h0000_0001);
        #1;
        tests++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_ready got %b exp 01", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 1, 0, 1, 0, 0, 32'h0000_ABCD);
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall%0d got %b exp 00", k, req_ready); end
            tests++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h8000_0000) begin errors++; $display("FAIL bp_hold%0d got %b/%h exp 01/80000000", k, rsp_valid, rsp_data); end
            tick();
        end
        rsp_ready = 2'b01;
        #1;
        tests++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_grant got %b exp 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tests++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h0000_ABCD) begin errors++; $display("FAIL bp_next got %b/%h exp 10/0000abcd", rsp_valid, rsp_data); end
        rsp_ready = 2'b10;
        tick();
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", busy); end
        exp_last = 1'b1;
    endtask

    task automatic test_random();
        logic g, p;
        exp_t e;
        for (int k = 0; k < 420; k++) begin
            req_valid   = 2'($urandom);
            rsp_ready   = 2'($urandom);
            req_lshift  = 2'($urandom);
            req_logical = 2'($urandom);
            req_rot     = 2'($urandom);
            req_shift   = 10'($urandom);
            req_in      = {$urandom, $urandom};
            if (k >= 400) begin
                req_valid = 2'b00;
                rsp_ready = 2'b11;
            end
            #1;
            tests++;
            if ((req_ready & ~req_valid) != 2'b00 || req_ready == 2'b11) begin
                errors++; $display("FAIL rand_ready cyc %0d got %b valid %b", k, req_ready, req_valid);
            end
            if (req_ready != 2'b00) begin
                g = req_ready[1];
                if (req_valid == 2'b11) begin
                    tests++;
                    if (g !== ~exp_last) begin errors++; $display("FAIL rand_rr cyc %0d got port %0d exp port %0d", k, g, ~exp_last); end
                end
                exp_last = g;
                e.port = g;
                e.data = model(req_in[32*g +: 32], int'(req_shift[5*g +: 5]), req_lshift[g], req_logical[g], req_rot[g]);
                q.push_back(e);
            end
            if (rsp_valid != 2'b00) begin
                tests++;
                if (rsp_valid == 2'b11) begin errors++; $display("FAIL rand_onehot cyc %0d got %b", k, rsp_valid); end
                p = rsp_valid[1];
                if (rsp_ready[p]) begin
                    tests++;
                    if (q.size() == 0) begin
                        errors++; $display("FAIL rand_spurious cyc %0d got port %0d data %h exp nothing", k, p, rsp_data);
                    end else begin
                        e = q.pop_front();
                        if (e.port !== p || e.data !== rsp_data) begin
                            errors++; $display("FAIL rand_rsp cyc %0d got port %0d data %h exp port %0d data %h", k, p, rsp_data, e.port, e.data);
                        end
                    end
                end
            end
            tick();
        end
        tests++; if (q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL rand_drain got %0d pending busy=%b exp 0/0", q.size(), busy); end
        q.delete();
    endtask

    task automatic test_reset_rot2();
        rsp_ready = 2'b00;
        set_req(0, 1, 1, 0, 1, 3, 32'h0000_0005);
        tick();
        req_valid = 2'b00;
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL rstrot_busy got %b exp 1", busy); end
        reset = 1'b0;
        #1;
        tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL rstrot_abort got %b/%b/%h exp 00/0/0", rsp_valid, busy, rsp_data); end
        tick();
        reset = 1'b1;
        exp_last = 1'b1;
        tick();
        tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rstrot_idle got %b/%b exp 00/0", rsp_valid, busy); end
        rsp_ready = 2'b01;
        set_req(0, 1, 1, 1, 0, 2, 32'h0000_0003);
        #1;
        tests++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstrot_ready got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        tests++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000_000C) begin errors++; $display("FAIL rstrot_result got %b/%h exp 01/0000000c", rsp_valid, rsp_data); end
        tick();
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrot_drain got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_asr();
        test_rot_left();
        test_rot_right_zero();
        test_contention();
        test_backpressure();
        test_random();
        test_reset_rot2();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational barrel shifter (bshift) between two requesters, e.g. the ALU issue path and the load/store byte-alignment path.
- Uses a valid/ready handshake with round-robin arbitration and a registered result.
- Adds a two-pass rotate sequence that runs the shifter twice.
- Sits between the requesters and a single bshift instance.

Parameters:
- RR_INIT, 1, index of the port treated as last-granted at reset. The default of 1 makes port 0 win the first contention.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, bit i = port i.
- req_ready  out  2  request accepted this cycle, bit i = port i.
- req_lshift  in  2  1 = left; 0 = right.
- req_logical  in  2  1 = logical right; 0 = arithmetic. Ignored for left shifts and rotates.
- req_rot  in  2  1 = rotate in the req_lshift direction.
- req_shift  in  10  shift amount; port i uses bits [5i+4:5i].
- req_in  in  64  operand; port i uses bits [32i+31:32i].
- rsp_valid  out  2  result valid for port i (one-hot or zero).
- rsp_ready  in  2  port i consumes the result.
- rsp_data  out  32  result, valid for the port flagged in rsp_valid.
- busy  out  1  state != IDLE.

Behaviour:
- States:
  - IDLE: no work held.
  - ROT2: second rotate pass pending.
  - HOLD: result registered, waiting for the owner.
- Reset (asynchronous, active-low):
  - state=IDLE, rsp_valid=0, rsp_data=0.
  - owner=0, rot temporaries=0, rr_last=RR_INIT.
  - req_ready=0 while reset is asserted.
- Accept condition: accept = (state==IDLE) | (state==HOLD & rsp_ready[owner]). Never accept in ROT2.
- Grant:
  - If exactly one port is valid, that port wins.
  - If both are valid, the port != rr_last wins.
  - req_ready[g] = accept & req_valid[g]. req_ready is combinational from req_valid, rsp_ready and state.
  - rr_last <= g on each grant.
- Shifter operand mux:
  - In ROT2: rot_in, 32-rot_n (5-bit wrap), opposite direction, logical=1.
  - Otherwise: the granted port's fields.
  - For rotates, pass A always uses logical=1.
- Plain shift (req_rot=0):
  - On grant, rsp_data <= bshift output; owner <= g; state -> HOLD.
  - Latency 1: rsp_valid[g] is high the cycle after the handshake.
- Rotate with amount 0: rsp_data <= operand; latency 1, same path as a plain shift.
- Rotate with amount n != 0:
  - Grant cycle: pass A result goes to rot_part; operand, n, direction and g are latched; state -> ROT2.
  - ROT2 cycle: rsp_data <= rot_part | pass B output; state -> HOLD.
  - Latency 2.
- HOLD:
  - rsp_valid[owner]=1; rsp_data and rsp_valid stay stable until rsp_ready[owner].
  - rsp_ready on the non-owner bit is ignored.
  - On a release with no new grant: state -> IDLE, rsp_valid -> 0.
- Back-to-back:
  - Release and a new grant in the same cycle gives throughput of 1 per cycle for plain shifts.
  - rsp_valid may switch owner without a gap.
- Request fields are sampled only on the handshake cycle. They may change freely afterwards.
- Reset asserted mid-ROT2 or mid-HOLD aborts the operation with no response. After release the block returns to IDLE with the reset values above.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=2'd0, ROT2=2'd1, HOLD=2'd2.
  - port count constant NPORT=2.
  - word width constant 32.
- One sub-module: the existing bshift shifter, instantiated once. All arbitration and sequencing lives in shift_arbiter.

Test Plan:
- Single arithmetic right shift:
  - Stimulus: port0, req_in=0x80000000, shift=4, lshift=0, logical=0.
  - Response: rsp_valid=2'b01 next cycle, rsp_data=0xF8000000.
- Rotate left:
  - Stimulus: port1, req_in=0x80000001, shift=1, rot=1, lshift=1.
  - Response: busy for 2 cycles, then rsp_valid=2'b10, rsp_data=0x00000003.
- Rotate right and rotate by 0:
  - Stimulus: rotate right 0x00000001 by 4, then rotate by 0 of 0x12345678.
  - Response: 0x10000000 after 2 cycles; 0x12345678 after 1 cycle.
- Contention:
  - Stimulus: both ports hold valid continuously, rsp_ready=2'b11.
  - Response: grants are 0,1,0,1 in consecutive cycles; req_ready is never 2'b11.
- Backpressure:
  - Stimulus: rsp_ready low for 3 cycles with port0 left shift 0x1 by 31.
  - Response: rsp_data stays 0x80000000 and rsp_valid stays high; no new grant until release.
- Reset during ROT2:
  - Stimulus: assert reset in the ROT2 cycle.
  - Response: rsp_valid=0 and busy=0 immediately. After release, the next port0 request completes normally.
